jtag_tap_target: RTL and testbench

Oversampled JTAG TAP responder: the far end of the AXI-to-JTAG master's TCK/TMS/TDI/TDO link. It samples the incoming JTAG pins in the system clock domain, runs the IEEE 1149.1 16-state TAP controller, and implements IR, BYPASS, IDCODE and one user data register. It exposes the user DR to the SoC as a parallel capture input and an update output. It is used as a loopback target for the JTAG master and as the debug-transport endpoint inside the FPGA design.

---
 rtl/jtag_pkg.sv | 60 ++++++
 rtl/jtag_pin_sync.sv | 41 ++++
 rtl/jtag_tap_target.sv | 127 ++++++++++++
 tb/tb_jtag_tap_target.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, fixed opcodes/patterns and the
// IEEE 1149.1 next-state function.
package jtag_pkg;

    localparam int unsigned TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_USER   = 2'd2
    } dr_sel_t;

    localparam logic [4:0] BYPASS_INSTR   = 5'h1F;
    localparam logic [1:0] CAP_IR_PATTERN = 2'b01;

    // 1149.1 state diagram, one TCK rise
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TAP_TLR:      n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   n = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   n = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   n = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   n = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings TCK/TMS/TDI into the system clock domain and detects TCK edges.
module jtag_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);

    logic [SYNC_STAGES-1:0] tck_q;
    logic [SYNC_STAGES-1:0] tms_q;
    logic [SYNC_STAGES-1:0] tdi_q;
    logic                   tck_prev;

    // equal depth on all three pins keeps TMS/TDI aligned with the TCK edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_q    <= '0;
            tms_q    <= '0;
            tdi_q    <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_q    <= {tck_q[SYNC_STAGES-2:0], tck};
            tms_q    <= {tms_q[SYNC_STAGES-2:0], tms};
            tdi_q    <= {tdi_q[SYNC_STAGES-2:0], tdi};
            tck_prev <= tck_q[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_prev;
    assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_prev;
    assign tms_s    = tms_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_target.sv
// Oversampled JTAG TAP responder with IR, BYPASS, IDCODE and one user DR.
module jtag_tap_target
    import jtag_pkg::*;
#(
    parameter int unsigned          IR_WIDTH     = 5,
    parameter int unsigned          DR_WIDTH     = 32,
    parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  USER_INSTR   = IR_WIDTH'(2),
    parameter int unsigned          SYNC_STAGES  = 2
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic                TCK,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    input  logic [DR_WIDTH-1:0] dr_capture_data,
    output logic [DR_WIDTH-1:0] dr_update_data,
    output logic                dr_update_valid,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [3:0]          tap_state
);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk      (s_axi_aclk),
        .rst_n    (s_axi_aresetn),
        .tck      (TCK),
        .tms      (TMS),
        .tdi      (TDI),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    tap_state_t          tap_q, tap_d;
    dr_sel_t             dr_sel;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         id_shift;
    logic [DR_WIDTH-1:0] dr_shift;
    logic                bypass;
    logic                tdo_d;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) tap_q <= TAP_TLR;
        else                tap_q <= tap_d;
    end

    always_comb begin
        tap_d = tap_q;
        if (tck_rise) tap_d = tap_next(tap_q, tms_s);
    end

    assign tap_state = tap_q;

    // unknown opcodes, all-ones included, fall through to BYPASS
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir_value == IR_WIDTH'(BYPASS_INSTR)) dr_sel = SEL_BYPASS;
        else if (ir_value == IDCODE_INSTR)       dr_sel = SEL_IDCODE;
        else if (ir_value == USER_INSTR)         dr_sel = SEL_USER;
    end

    always_comb begin
        tdo_d = 1'b0;
        case (tap_q)
            TAP_SH_IR: tdo_d = ir_shift[0];
            TAP_SH_DR: begin
                case (dr_sel)
                    SEL_IDCODE: tdo_d = id_shift[0];
                    SEL_USER:   tdo_d = dr_shift[0];
                    default:    tdo_d = bypass;
                endcase
            end
            default: tdo_d = 1'b0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ir_value        <= IDCODE_INSTR;
            ir_shift        <= '0;
            id_shift        <= '0;
            dr_shift        <= '0;
            bypass          <= 1'b0;
            dr_update_data  <= '0;
            dr_update_valid <= 1'b0;
            TDO             <= 1'b0;
        end else begin
            dr_update_valid <= 1'b0;
            if (tck_rise) begin
                case (tap_q)
                    TAP_CAP_IR: ir_shift <= IR_WIDTH'(CAP_IR_PATTERN);
                    TAP_SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
                    TAP_UPD_IR: ir_value <= ir_shift;
                    TAP_CAP_DR: begin
                        case (dr_sel)
                            SEL_IDCODE: id_shift <= IDCODE_VALUE;
                            SEL_USER:   dr_shift <= dr_capture_data;
                            default:    bypass   <= 1'b0;
                        endcase
                    end
                    TAP_SH_DR: begin
                        case (dr_sel)
                            SEL_IDCODE: id_shift <= {tdi_s, id_shift[31:1]};
                            SEL_USER:   dr_shift <= {tdi_s, dr_shift[DR_WIDTH-1:1]};
                            default:    bypass   <= tdi_s;
                        endcase
                    end
                    TAP_UPD_DR: begin
                        if (dr_sel == SEL_USER) begin
                            dr_update_data  <= dr_shift;
                            dr_update_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (tap_d == TAP_TLR) ir_value <= IDCODE_INSTR;
            end
            if (tck_fall) TDO <= tdo_d;
        end
    end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Randomized and directed bench for jtag_tap_target against a table-driven TAP model.
module tb_jtag_tap_target;

    localparam int P = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        TCK, TMS, TDI;
    logic        TDO;
    logic [31:0] dr_capture_data;
    logic [31:0] dr_update_data;
    logic        dr_update_valid;
    logic [4:0]  ir_value;
    logic [3:0]  tap_state;

    jtag_tap_target dut (
        .s_axi_aclk      (clk),
        .s_axi_aresetn   (rst_n),
        .TCK             (TCK),
        .TMS             (TMS),
        .TDI             (TDI),
        .TDO             (TDO),
        .dr_capture_data (dr_capture_data),
        .dr_update_data  (dr_update_data),
        .dr_update_valid (dr_update_valid),
        .ir_value        (ir_value),
        .tap_state       (tap_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    always @(posedge clk) if (dr_update_valid === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // next state per encoding, nibble i = successor of state i
    logic [63:0] nxt0 = 64'hCACC_BABA_62CE_3232;
    logic [63:0] nxt1 = 64'hF977_89DD_417F_0155;

    logic [3:0]  m_state = 4'hF;
    logic [4:0]  m_ir = 5'h01, m_ir_sh = '0;
    logic [31:0] m_dr = '0, m_id = '0, m_upd = '0;
    logic        m_byp = 1'b0;

    task automatic model_reset();
        m_state = 4'hF; m_ir = 5'h01; m_ir_sh = '0;
        m_dr = '0; m_id = '0; m_upd = '0; m_byp = 1'b0;
    endtask

    // one full TCK period; returns TDO as seen after the falling edge
    task automatic step(input logic tms, input logic tdi, output logic tdo_o);
        int p0, exp_p;
        logic exp_tdo;
        exp_p = 0;
        case (m_state)
            4'hE: m_ir_sh = 5'b00001;
            4'hA: m_ir_sh = {tdi, m_ir_sh[4:1]};
            4'hD: m_ir = m_ir_sh;
            4'h6: begin
                if (m_ir == 5'h02)      m_dr = dr_capture_data;
                else if (m_ir == 5'h01) m_id = 32'h1000_0001;
                else                    m_byp = 1'b0;
            end
            4'h2: begin
                if (m_ir == 5'h02)      m_dr = {tdi, m_dr[31:1]};
                else if (m_ir == 5'h01) m_id = {tdi, m_id[31:1]};
                else                    m_byp = tdi;
            end
            4'h5: if (m_ir == 5'h02) begin m_upd = m_dr; exp_p = 1; end
            default: ;
        endcase
        m_state = tms ? nxt1[int'(m_state)*4 +: 4] : nxt0[int'(m_state)*4 +: 4];
        if (m_state == 4'hF) m_ir = 5'h01;
        exp_tdo = 1'b0;
        if (m_state == 4'hA) exp_tdo = m_ir_sh[0];
        else if (m_state == 4'h2)
            exp_tdo = (m_ir == 5'h02) ? m_dr[0] : (m_ir == 5'h01) ? m_id[0] : m_byp;

        TMS = tms; TDI = tdi; p0 = pulse_cnt;
        TCK = 1'b1;
        repeat (P) @(posedge clk);
        #1 TCK = 1'b0;
        repeat (P) @(posedge clk);
        #1;
        check("tap_state", 32'(tap_state), 32'(m_state));
        check("ir_value", 32'(ir_value), 32'(m_ir));
        check("tdo", 32'(TDO), 32'(exp_tdo));
        check("upd_data", dr_update_data, m_upd);
        check("upd_pulses", 32'(pulse_cnt - p0), 32'(exp_p));
        tdo_o = TDO;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; TCK = 1'b0; TMS = 1'b0; TDI = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // from RTI: load IR, return to RTI; collects TDO seen in Shift-IR
    task automatic shift_ir(input logic [4:0] val, output logic [4:0] tout);
        logic t;
        step(1'b1, 1'b0, t); step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t); tout[0] = t;
        for (int i = 0; i < 5; i++) begin
            step(i == 4, val[i], t);
            if (i < 4) tout[i+1] = t;
        end
        step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    endtask

    // from RTI: capture, shift n bits, update, return to RTI
    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic t;
        dout = '0;
        step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t); dout[0] = t;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], t);
            if (i < n - 1) dout[i+1] = t;
        end
        step(1'b1, 1'b0, t); step(1'b0, 1'b0, t);
    endtask

    initial begin
        logic        t;
        logic [31:0] d;
        logic [4:0]  irq;
        int          p0;

        rst_n = 1'b0; TCK = 1'b0; TMS = 1'b0; TDI = 1'b0;
        dr_capture_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(tap_state), 32'hF);
        check("rst_ir", 32'(ir_value), 32'h01);
        check("rst_tdo", 32'(TDO), 32'h0);
        check("rst_upd", dr_update_data, 32'h0);
        do_reset();

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
        check("tlr_state", 32'(tap_state), 32'hF);

        step(1'b0, 1'b0, t);
        shift_dr(32, 32'h0, d);
        check("idcode_read", d, 32'h1000_0001);

        shift_ir(5'h02, irq);
        check("capir_bits", 32'(irq[1:0]), 32'h1);
        dr_capture_data = 32'hDEAD_BEEF;
        p0 = pulse_cnt;
        shift_dr(32, 32'h1234_5678, d);
        check("user_capture", d, 32'hDEAD_BEEF);
        check("user_update", dr_update_data, 32'h1234_5678);
        check("user_pulse_once", 32'(pulse_cnt - p0), 32'h1);

        shift_ir(5'h1F, irq);
        check("ir_bypass", 32'(ir_value), 32'h1F);
        p0 = pulse_cnt;
        shift_dr(4, 32'b1101, d);
        check("bypass_tdo", 32'(d[3:0]), 32'b1010);
        check("bypass_no_pulse", 32'(pulse_cnt - p0), 32'h0);

        do_reset();
        for (int i = 0; i < 900; i++) begin
            dr_capture_data = $urandom();
            step($urandom_range(3) == 0, 1'($urandom_range(1)), t);
        end

        do_reset();
        step(1'b0, 1'b0, t);
        shift_ir(5'h02, irq);
        dr_capture_data = 32'hA5A5_0F0F;
        step(1'b1, 1'b0, t); step(1'b0, 1'b0, t); step(1'b0, 1'b0, t);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(1)), t);
        p0 = pulse_cnt;
        TMS = 1'b0; TDI = 1'b1; TCK = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(tap_state), 32'hF);
        check("midrst_ir", 32'(ir_value), 32'h01);
        check("midrst_tdo", 32'(TDO), 32'h0);
        check("midrst_upd", dr_update_data, 32'h0);
        model_reset();
        TCK = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("postrst_state", 32'(tap_state), 32'hF);
        check("postrst_upd", dr_update_data, 32'h0);
        check("postrst_no_pulse", 32'(pulse_cnt - p0), 32'h0);
        step(1'b0, 1'b0, t);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
